// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment codes, scan states and the nibble encoder.
package seg7_pkg;

   // Segment codes {dp,g,f,e,d,c,b,a}, active-high
   localparam logic [7:0] SEG_DIGIT [0:9] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
   };
   localparam logic [7:0] SEG_DASH = 8'h40;
   localparam logic [7:0] SEG_OFF  = 8'h00;

   typedef enum logic {BLANK, SHOW} scan_state_t;

   // Non-decimal nibbles render as a dash so corrupt BCD is visible
   function automatic logic [7:0] seg7_encode(input logic [3:0] i_nib);
      logic [7:0] w_code;
      case (i_nib)
         4'd0:    w_code = SEG_DIGIT[0];
         4'd1:    w_code = SEG_DIGIT[1];
         4'd2:    w_code = SEG_DIGIT[2];
         4'd3:    w_code = SEG_DIGIT[3];
         4'd4:    w_code = SEG_DIGIT[4];
         4'd5:    w_code = SEG_DIGIT[5];
         4'd6:    w_code = SEG_DIGIT[6];
         4'd7:    w_code = SEG_DIGIT[7];
         4'd8:    w_code = SEG_DIGIT[8];
         4'd9:    w_code = SEG_DIGIT[9];
         default: w_code = SEG_DASH;
      endcase
      return w_code;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-synchronous value commit.
module seg_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   input  logic                    blank_lz,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [7:0]              digit_code,
   output logic                    frame_done
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]        r_cnt;
   logic [IDX_W-1:0]        r_idx;
   scan_state_t             r_state;
   logic [4*NUM_DIGITS-1:0] r_pend;
   logic [4*NUM_DIGITS-1:0] r_display;
   logic                    r_load_ready;
   logic [NUM_DIGITS-1:0]   r_sel;
   logic [7:0]              r_code;
   logic                    r_frame_done;

   logic                    w_commit;
   logic                    w_accept;
   logic [3:0]              w_nib;
   logic                    w_hi_zero;
   logic [7:0]              w_show_code;
   logic [NUM_DIGITS-1:0]   w_show_sel;

   // Frame boundary: the edge that opens digit 0's blank phase
   assign w_commit = (r_cnt == '0) && (r_idx == '0);
   assign w_accept = load_valid && r_load_ready;

   // Select the active nibble and detect whether it and all higher nibbles are zero
   always_comb begin
      w_nib     = 4'd0;
      w_hi_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i == int'(r_idx)) w_nib = r_display[4*i +: 4];
         if ((i >= int'(r_idx)) && (r_display[4*i +: 4] != 4'd0)) w_hi_zero = 1'b0;
      end
      w_show_code = (blank_lz && (r_idx != '0) && w_hi_zero) ? SEG_OFF : seg7_encode(w_nib);
      w_show_sel  = NUM_DIGITS'(1) << r_idx;
   end

   // Slot counter and digit index; free-running so the frame period never depends on loads
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
         r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Pending/display registers; ready low means pending holds an uncommitted value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend       <= '0;
         r_display    <= '0;
         r_load_ready <= 1'b1;
      end else if (w_commit && !r_load_ready) begin
         r_display    <= r_pend;
         r_load_ready <= 1'b1;
      end else if (w_accept) begin
         r_pend       <= load_value;
         r_load_ready <= 1'b0;
      end
   end

   // Blank/show FSM with registered select, code and frame pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= BLANK;
         r_sel        <= '0;
         r_code       <= SEG_OFF;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);
         case (r_state)
            BLANK: begin
               if (r_cnt == CNT_SHOW) begin
                  r_state <= SHOW;
                  r_sel   <= w_show_sel;
                  r_code  <= w_show_code;
               end else begin
                  r_sel  <= '0;
                  r_code <= SEG_OFF;
               end
            end
            SHOW: begin
               if (r_cnt == '0) begin
                  r_state <= BLANK;
                  r_sel   <= '0;
                  r_code  <= SEG_OFF;
               end else begin
                  // Refresh every cycle so blank_lz takes effect live
                  r_sel  <= w_show_sel;
                  r_code <= w_show_code;
               end
            end
            default: begin
               r_state <= BLANK;
               r_sel   <= '0;
               r_code  <= SEG_OFF;
            end
         endcase
      end
   end

   assign load_ready = r_load_ready;
   assign digit_sel  = r_sel;
   assign digit_code = r_code;
   assign frame_done = r_frame_done;

endmodule
